// File: rtl/data_mem_2r1w.sv
// Two-read, one-write data memory with registered reads, optional write forwarding
// and a sequencer that zeroes every word after reset or on a clr request.
module data_mem_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              busy
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_fire, wr_fire;
    logic              fwd1, fwd2;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The clear sequencer shares the single write port, so the array stays RAM-inferable.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                cnt_next  = cnt + ADDR_W'(1);
                if (cnt == '1)
                    state_next = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_next = CLEAR;
                end else if (en) begin
                    wr_fire = wr_en;
                    rd_fire = rd_en;
                    mem_we  = wr_en;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign fwd1 = BYPASS && wr_fire && (rd_addr1 == wr_addr);
    assign fwd2 = BYPASS && wr_fire && (rd_addr2 == wr_addr);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data1 <= fwd1 ? wr_data : mem[rd_addr1];
                rd_data2 <= fwd2 ? wr_data : mem[rd_addr2];
            end
        end
    end

    assign busy = (state == CLEAR);
endmodule

// File: tb/tb_data_mem_2r1w.sv
// Directed bench: default build, a BYPASS=0 build sharing its stimulus,
// and a 16-bit x 16-word build sharing the control strobes.
module tb_data_mem_2r1w;
    logic       clk = 1'b0;
    logic       rst, en, clr, wr_en, rd_en;
    logic [5:0] wr_addr, rd_addr1, rd_addr2;
    logic [7:0] wr_data;
    logic [7:0] rd_data1, rd_data2, nb_data1, nb_data2;
    logic       rd_valid, busy, nb_valid, nb_busy;
    logic [3:0]  p_wr_addr, p_rd_addr1, p_rd_addr2;
    logic [15:0] p_wr_data, p_rd_data1, p_rd_data2;
    logic        p_rd_valid, p_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_2r1w dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid), .busy(busy)
    );

    data_mem_2r1w #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_data1), .rd_data2(nb_data2), .rd_valid(nb_valid), .busy(nb_busy)
    );

    data_mem_2r1w #(.DATA_W(16), .ADDR_W(4)) dut_p (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .wr_en(wr_en), .wr_addr(p_wr_addr),
        .wr_data(p_wr_data), .rd_en(rd_en), .rd_addr1(p_rd_addr1), .rd_addr2(p_rd_addr2),
        .rd_data1(p_rd_data1), .rd_data2(p_rd_data2), .rd_valid(p_rd_valid), .busy(p_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until busy drops (bounded at 200).
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        int n, np;
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
        checks++; if ({rd_data1, rd_data2} !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", {rd_data1, rd_data2}); end
        rst = 1'b0;
        n = 0; np = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (!p_busy && np == 0) np = n;
            if (!busy) break;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL rst_busy_len: got %0d want 64", n); end
        checks++; if (np !== 16) begin errors++; $display("FAIL p_busy_len: got %0d want 16", np); end
        en = 1'b1; rd_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rd_addr1 = 6'(a);
            rd_addr2 = 6'(63 - a);
            tick();
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL clr_valid[%0d]: got %b want 1", a, rd_valid); end
            checks++; if ({rd_data1, rd_data2} !== 16'h0000) begin errors++; $display("FAIL clr_data[%0d]: got %h want 0000", a, {rd_data1, rd_data2}); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 6'd3;  wr_data = 8'hA5; tick();
        wr_addr = 6'd63; wr_data = 8'h3C; tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 6'd3; rd_addr2 = 6'd63; tick();
        rd_en = 1'b0;
        checks++; if (rd_data1 !== 8'hA5) begin errors++; $display("FAIL wr_rd1: got %h want a5", rd_data1); end
        checks++; if (rd_data2 !== 8'h3C) begin errors++; $display("FAIL wr_rd2: got %h want 3c", rd_data2); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid); end
        tick();
        checks++; if (rd_data1 !== 8'hA5) begin errors++; $display("FAIL rd_hold: got %h want a5", rd_data1); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h11; tick();
        wr_data = 8'h77; rd_en = 1'b1; rd_addr1 = 6'd5; rd_addr2 = 6'd5; tick();
        checks++; if ({rd_data1, rd_data2} !== 16'h7777) begin errors++; $display("FAIL byp1: got %h want 7777", {rd_data1, rd_data2}); end
        checks++; if ({nb_data1, nb_data2} !== 16'h1111) begin errors++; $display("FAIL byp0: got %h want 1111", {nb_data1, nb_data2}); end
        wr_en = 1'b0; tick();
        checks++; if ({nb_data1, nb_data2} !== 16'h7777) begin errors++; $display("FAIL byp0_after: got %h want 7777", {nb_data1, nb_data2}); end
        wr_en = 1'b1; wr_data = 8'h99; rd_addr2 = 6'd6; tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if ({rd_data1, rd_data2} !== 16'h9900) begin errors++; $display("FAIL byp_split: got %h want 9900", {rd_data1, rd_data2}); end
        checks++; if ({nb_data1, nb_data2} !== 16'h7700) begin errors++; $display("FAIL byp0_split: got %h want 7700", {nb_data1, nb_data2}); end
    endtask

    task automatic test_enable();
        rd_en = 1'b1; rd_addr1 = 6'd3; rd_addr2 = 6'd63; tick();
        en = 1'b0; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h00; rd_addr1 = 6'd5; rd_addr2 = 6'd5; tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL en0_valid: got %b want 0", rd_valid); end
        checks++; if ({rd_data1, rd_data2} !== 16'hA53C) begin errors++; $display("FAIL en0_hold: got %h want a53c", {rd_data1, rd_data2}); end
        en = 1'b1; wr_en = 1'b0; rd_addr1 = 6'd3; rd_addr2 = 6'd5; tick();
        rd_en = 1'b0;
        checks++; if ({rd_data1, rd_data2} !== 16'hA599) begin errors++; $display("FAIL en0_contents: got %h want a599", {rd_data1, rd_data2}); end
    endtask

    task automatic test_clr();
        int n, bad;
        clr = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'hFF; rd_en = 1'b1; rd_addr1 = 6'd0; rd_addr2 = 6'd0;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b want 1", busy); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_drop_valid: got %b want 0", rd_valid); end
        n = 0; bad = 0;
        for (int i = 0; i < 200; i++) begin
            clr = (i == 20);
            tick();
            n++;
            if (rd_valid !== 1'b0) bad++;
            if (!busy) break;
        end
        clr = 1'b0;
        checks++; if (n !== 64) begin errors++; $display("FAIL clr_busy_len: got %0d want 64", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clr_valid_during: got %0d high cycles want 0", bad); end
        checks++; if ({rd_data1, rd_data2} !== 16'hA599) begin errors++; $display("FAIL clr_hold: got %h want a599", {rd_data1, rd_data2}); end
        rd_addr1 = 6'd0; rd_addr2 = 6'd3; tick();
        rd_en = 1'b0;
        checks++; if ({rd_data1, rd_data2} !== 16'h0000) begin errors++; $display("FAIL clr_after: got %h want 0000", {rd_data1, rd_data2}); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h5A; tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr1 = 6'd7; tick();
        rd_en = 1'b0;
        clr = 1'b1; tick();
        clr = 1'b0;
        repeat (29) tick();
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got busy=%b valid=%b want 1 0", busy, rd_valid); end
        checks++; if (rd_data1 !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", rd_data1); end
        tick();
        rst = 1'b0;
        count_busy(n);
        checks++; if (n !== 64) begin errors++; $display("FAIL rst_mid_len: got %0d want 64", n); end
        rd_en = 1'b1; rd_addr1 = 6'd7; rd_addr2 = 6'd5; tick();
        rd_en = 1'b0;
        checks++; if ({rd_data1, rd_data2} !== 16'h0000) begin errors++; $display("FAIL rst_mid_contents: got %h want 0000", {rd_data1, rd_data2}); end
    endtask

    task automatic test_param();
        int n;
        rst = 1'b1; tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (!p_busy) break;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL p_len: got %0d want 16", n); end
        wr_en = 1'b1; p_wr_addr = 4'd15; p_wr_data = 16'hBEEF; tick();
        wr_en = 1'b0; rd_en = 1'b1; p_rd_addr1 = 4'd0; p_rd_addr2 = 4'd15; tick();
        rd_en = 1'b0;
        checks++; if (p_rd_data2 !== 16'hBEEF) begin errors++; $display("FAIL p_rd2: got %h want beef", p_rd_data2); end
        checks++; if (p_rd_data1 !== 16'h0000 || p_rd_valid !== 1'b1) begin errors++; $display("FAIL p_rd1: got %h/%b want 0000/1", p_rd_data1, p_rd_valid); end
        checks++; if (busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL main_busy_ignore: got busy=%b valid=%b want 1 0", busy, rd_valid); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        p_wr_addr = '0; p_wr_data = '0; p_rd_addr1 = '0; p_rd_addr2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_enable();
        test_clr();
        test_reset_mid_clear();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
